// File: rtl/ahb_burst_master.sv
// AHB-Lite master-side burst engine for the I-cache refill path.
// Takes one burst request, sequences its address phases (SINGLE, INCR, INCRx,
// WRAPx) with hready stalls and 1KB-boundary restarts, returns read beats tagged
// with their data-phase address, and pulses done (with err on an ERROR abort).
module ahb_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [2:0]        req_burst,
  input  logic [2:0]        req_size,
  input  logic [LEN_W-1:0]  req_len,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hburst,
  output logic [2:0]        hsize,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              done,
  output logic              err
);

  localparam int MAX_SIZE = $clog2(DATA_W / 8);
  localparam int CNT_W    = LEN_W + 16;

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_NSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [CNT_W-1:0]  addrLeft_q, addrLeft_d;
  logic [ADDR_W-1:0] wrapMask_q, wrapMask_d;
  logic              isWrap_q, isWrap_d;
  logic              dataPhase_q, dataPhase_d;
  logic [ADDR_W-1:0] dataAddr_q, dataAddr_d;
  logic              rdValid_q, rdValid_d;
  logic [DATA_W-1:0] rdData_q, rdData_d;
  logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [2:0]        reqSizeEff;
  logic [ADDR_W-1:0] reqIncr, reqAligned, reqWrapMask;
  logic [CNT_W-1:0]  reqBeats;
  logic              reqIsWrap;
  logic [ADDR_W-1:0] curIncr, incrAddr, wrapAddr;
  logic              errHit;

  // Decode an incoming request: clamp size, align start address, beat count and wrap window.
  always_comb begin
    reqSizeEff = (req_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : req_size;
    reqIncr    = ADDR_W'(1) << reqSizeEff;
    reqAligned = req_addr & ~(reqIncr - ADDR_W'(1));
    reqIsWrap  = (req_burst != 3'd0) && !req_burst[0];
    case (req_burst)
      3'd0:       reqBeats = CNT_W'(1);
      3'd1:       reqBeats = CNT_W'(req_len) + CNT_W'(1);
      3'd2, 3'd3: reqBeats = CNT_W'(4);
      3'd4, 3'd5: reqBeats = CNT_W'(8);
      default:    reqBeats = CNT_W'(16);
    endcase
    reqWrapMask = (ADDR_W'(reqBeats) << reqSizeEff) - ADDR_W'(1);
  end

  // Candidate next beat addresses for incrementing and wrapping bursts.
  always_comb begin
    curIncr  = ADDR_W'(1) << hsize_q;
    incrAddr = haddr_q + curIncr;
    wrapAddr = (haddr_q & ~wrapMask_q) | (incrAddr & wrapMask_q);
  end

  // Next-state and bus sequencing; an ERROR in a data phase overrides everything else.
  always_comb begin
    state_d     = state_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hburst_d    = hburst_q;
    hsize_d     = hsize_q;
    addrLeft_d  = addrLeft_q;
    wrapMask_d  = wrapMask_q;
    isWrap_d    = isWrap_q;
    dataPhase_d = dataPhase_q;
    dataAddr_d  = dataAddr_q;
    rdValid_d   = 1'b0;
    rdData_d    = rdData_q;
    rdAddr_d    = rdAddr_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    errHit      = dataPhase_q && hresp;

    if (dataPhase_q && hready) begin
      dataPhase_d = 1'b0;
      if (!hwrite_q && !hresp) begin
        rdValid_d = 1'b1;
        rdData_d  = hrdata;
        rdAddr_d  = dataAddr_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d    = S_ADDR;
          haddr_d    = reqAligned;
          htrans_d   = TR_NSEQ;
          hwrite_d   = req_write;
          hburst_d   = req_burst;
          hsize_d    = reqSizeEff;
          addrLeft_d = reqBeats;
          wrapMask_d = reqWrapMask;
          isWrap_d   = reqIsWrap;
        end
      end
      S_ADDR: begin
        if (hready) begin
          dataPhase_d = 1'b1;
          dataAddr_d  = haddr_q;
          if (addrLeft_q == CNT_W'(1)) begin
            state_d    = S_LAST;
            htrans_d   = TR_IDLE;
            addrLeft_d = '0;
          end else begin
            addrLeft_d = addrLeft_q - CNT_W'(1);
            haddr_d    = isWrap_q ? wrapAddr : incrAddr;
            htrans_d   = (!isWrap_q && (incrAddr[9:0] == 10'd0)) ? TR_NSEQ : TR_SEQ;
          end
        end
      end
      S_LAST: begin
        if (hready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (errHit) begin
      state_d     = S_IDLE;
      htrans_d    = TR_IDLE;
      dataPhase_d = 1'b0;
      addrLeft_d  = '0;
      rdValid_d   = 1'b0;
      done_d      = 1'b1;
      err_d       = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Bus, counter and read-return registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      haddr_q     <= '0;
      htrans_q    <= TR_IDLE;
      hwrite_q    <= 1'b0;
      hburst_q    <= 3'd0;
      hsize_q     <= 3'd0;
      addrLeft_q  <= '0;
      wrapMask_q  <= '0;
      isWrap_q    <= 1'b0;
      dataPhase_q <= 1'b0;
      dataAddr_q  <= '0;
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
      rdAddr_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hburst_q    <= hburst_d;
      hsize_q     <= hsize_d;
      addrLeft_q  <= addrLeft_d;
      wrapMask_q  <= wrapMask_d;
      isWrap_q    <= isWrap_d;
      dataPhase_q <= dataPhase_d;
      dataAddr_q  <= dataAddr_d;
      rdValid_q   <= rdValid_d;
      rdData_q    <= rdData_d;
      rdAddr_q    <= rdAddr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hburst    = hburst_q;
  assign hsize     = hsize_q;
  assign rd_valid  = rdValid_q;
  assign rd_data   = rdData_q;
  assign rd_addr   = rdAddr_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Testbench for ahb_burst_master: a behavioural AHB slave returns address-derived
// data, a monitor logs accepted address phases and returned beats, and each test
// compares those logs against a burst model computed from the AHB address rules.
module tb_ahb_burst_master;

  localparam int MAXS = 2;
  localparam logic [1:0] NSEQ = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [2:0]  req_burst = '0;
  logic [2:0]  req_size = '0;
  logic [7:0]  req_len = '0;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [31:0] rd_addr;
  logic        done;
  logic        err;

  int cmpCount = 0;
  int failCount = 0;

  // Monitor logs
  int cycle = 0;
  logic [31:0] addrQ[$];
  logic [1:0]  transQ[$];
  logic [31:0] rdAddrQ[$];
  logic [31:0] rdDataQ[$];
  int doneCnt = 0, doneCycle = 0, lastRdCycle = 0, hrespCycle = 0;
  int stallCnt = 0, holdErr = 0, busyCnt = 0;
  logic doneErr = 1'b0;
  logic [1:0] doneTrans = '0;
  logic prevStall = 1'b0;
  logic [31:0] prevAddr = '0;
  logic [1:0] prevTrans = '0;

  // Slave state and configuration
  logic willAccept = 1'b0, dpDoneNow = 1'b0, dpValid = 1'b0;
  logic [31:0] willAddr = '0, dpAddr = '0;
  int beatIdx = 0, stallBeat = -1, stallLeft = 0, errBeat = -1;
  bit randReady = 1'b0;

  // Reference model output
  logic [31:0] expAddr[$];
  logic [1:0]  expTrans[$];

  always #5 clk = ~clk;

  ahb_burst_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_burst(req_burst),
    .req_size(req_size), .req_len(req_len), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hburst(hburst), .hsize(hsize), .hready(hready),
    .hresp(hresp), .hrdata(hrdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_addr(rd_addr), .done(done), .err(err)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Burst model: beat addresses and transfer types from the AHB wrap/increment rules.
  function automatic void buildExpected(input logic [31:0] a, input logic [2:0] b,
                                        input logic [2:0] s, input logic [7:0] len);
    int sz, beats;
    logic [31:0] incr, start, total, base, cur;
    sz = (int'(s) > MAXS) ? MAXS : int'(s);
    incr = 32'd1 << sz;
    start = a - (a % incr);
    case (b)
      3'd0: beats = 1;
      3'd1: beats = int'(len) + 1;
      3'd2, 3'd3: beats = 4;
      3'd4, 3'd5: beats = 8;
      default: beats = 16;
    endcase
    total = incr * 32'(beats);
    base = start - (start % total);
    expAddr.delete();
    expTrans.delete();
    for (int i = 0; i < beats; i++) begin
      if (b == 3'd2 || b == 3'd4 || b == 3'd6) begin
        cur = base + ((start - base + incr * 32'(i)) % total);
        expTrans.push_back((i == 0) ? NSEQ : SEQ);
      end else begin
        cur = start + incr * 32'(i);
        expTrans.push_back((i == 0 || (cur % 32'd1024) == 32'd0) ? NSEQ : SEQ);
      end
      expAddr.push_back(cur);
    end
  endfunction

  // Monitor: samples mid-cycle, logging bus acceptances, stalls, returned beats and done.
  always @(negedge clk) begin
    cycle++;
    willAccept = rstn && (htrans != 2'b00) && hready;
    willAddr = haddr;
    dpDoneNow = dpValid && hready;
    if (willAccept) begin
      addrQ.push_back(haddr);
      transQ.push_back(htrans);
    end
    if (rstn && htrans != 2'b00 && !hready) begin
      stallCnt++;
      if (prevStall && (haddr !== prevAddr || htrans !== prevTrans)) holdErr++;
      prevStall = 1'b1;
    end else begin
      prevStall = 1'b0;
    end
    prevAddr = haddr;
    prevTrans = htrans;
    if (htrans == 2'b01) busyCnt++;
    if (rd_valid) begin
      rdAddrQ.push_back(rd_addr);
      rdDataQ.push_back(rd_data);
      lastRdCycle = cycle;
    end
    if (done) begin
      doneCnt++;
      doneCycle = cycle;
      doneErr = err;
      doneTrans = htrans;
    end
    if (dpValid && hresp) hrespCycle = cycle;
  end

  // Slave: tracks its data phase and drives hready/hresp/hrdata just after each edge.
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      dpValid = 1'b0;
    end else begin
      if (dpDoneNow) dpValid = 1'b0;
      if (willAccept) begin
        dpValid = 1'b1;
        dpAddr = willAddr;
        beatIdx++;
      end
    end
    hresp = 1'b0;
    if (dpValid && beatIdx == errBeat) begin
      hready = 1'b1;
      hresp = 1'b1;
    end else if (dpValid && beatIdx == stallBeat && stallLeft > 0) begin
      hready = 1'b0;
      stallLeft--;
    end else begin
      hready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    hrdata = dpValid ? memf(dpAddr) : $urandom;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clearLogs();
    addrQ.delete(); transQ.delete(); rdAddrQ.delete(); rdDataQ.delete();
    doneCnt = 0; stallCnt = 0; holdErr = 0;
    beatIdx = 0; stallBeat = -1; stallLeft = 0; errBeat = -1;
  endtask

  task automatic startBurst(input logic [31:0] a, input logic w, input logic [2:0] b,
                            input logic [2:0] s, input logic [7:0] len);
    req_addr = a; req_write = w; req_burst = b; req_size = s; req_len = len;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Waits for done (bounded) and returns mid-cycle once the monitor has logged it.
  task automatic waitDone(input int budget, output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        timedOut = 1'b0;
        break;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick(); tick();
    cmpCount++; if ({htrans, haddr, hwrite, hburst, hsize} !== 41'd0) begin failCount++;
      $display("FAIL reset_bus got htrans=%b haddr=%h hwrite=%b hburst=%0d hsize=%0d want all 0", htrans, haddr, hwrite, hburst, hsize); end
    cmpCount++; if (req_ready !== 1'b1) begin failCount++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    cmpCount++; if ({rd_valid, done, err} !== 3'b000) begin failCount++; $display("FAIL reset_pulses got %b want 000", {rd_valid, done, err}); end
    cmpCount++; if ({rd_data, rd_addr} !== 64'd0) begin failCount++; $display("FAIL reset_rd got data=%h addr=%h want 0", rd_data, rd_addr); end
    rstn = 1'b1;
    tick(); tick();
  endtask

  task automatic test_wrap4();
    bit to;
    clearLogs();
    buildExpected(32'h34, 3'd2, 3'd2, 8'd0);
    startBurst(32'h34, 1'b0, 3'd2, 3'd2, 8'd0);
    cmpCount++; if (htrans !== NSEQ || haddr !== 32'h34) begin failCount++; $display("FAIL wrap4_first got %b/%h want 10/00000034", htrans, haddr); end
    waitDone(100, to);
    cmpCount++; if (to) begin failCount++; $display("FAIL wrap4_timeout got no done want done"); end
    cmpCount++; if (addrQ.size() !== expAddr.size()) begin failCount++; $display("FAIL wrap4_nbeats got %0d want %0d", addrQ.size(), expAddr.size()); end
    for (int i = 0; i < addrQ.size() && i < expAddr.size(); i++) begin
      cmpCount++; if (addrQ[i] !== expAddr[i] || transQ[i] !== expTrans[i]) begin failCount++;
        $display("FAIL wrap4_addr[%0d] got %h/%b want %h/%b", i, addrQ[i], transQ[i], expAddr[i], expTrans[i]); end
    end
    cmpCount++; if (rdAddrQ.size() !== 4) begin failCount++; $display("FAIL wrap4_nrd got %0d want 4", rdAddrQ.size()); end
    for (int i = 0; i < rdAddrQ.size() && i < expAddr.size(); i++) begin
      cmpCount++; if (rdAddrQ[i] !== expAddr[i] || rdDataQ[i] !== memf(expAddr[i])) begin failCount++;
        $display("FAIL wrap4_rd[%0d] got %h:%h want %h:%h", i, rdAddrQ[i], rdDataQ[i], expAddr[i], memf(expAddr[i])); end
    end
    cmpCount++; if (doneCycle !== lastRdCycle || doneErr !== 1'b0) begin failCount++;
      $display("FAIL wrap4_done got cycle %0d err %b want cycle %0d err 0", doneCycle, doneErr, lastRdCycle); end
    cmpCount++; if (req_ready !== 1'b1) begin failCount++; $display("FAIL wrap4_ready_at_done got %b want 1", req_ready); end
  endtask

  task automatic test_wrap8();
    bit to;
    clearLogs();
    buildExpected(32'h0E, 3'd4, 3'd1, 8'd0);
    startBurst(32'h0E, 1'b0, 3'd4, 3'd1, 8'd0);
    cmpCount++; if (hsize !== 3'd1 || hburst !== 3'd4 || hwrite !== 1'b0) begin failCount++;
      $display("FAIL wrap8_ctrl got size %0d burst %0d write %b want 1 4 0", hsize, hburst, hwrite); end
    waitDone(100, to);
    cmpCount++; if (to || addrQ.size() !== 8) begin failCount++; $display("FAIL wrap8_nbeats got %0d timeout %b want 8", addrQ.size(), to); end
    for (int i = 0; i < addrQ.size() && i < expAddr.size(); i++) begin
      cmpCount++; if (addrQ[i] !== expAddr[i] || transQ[i] !== expTrans[i]) begin failCount++;
        $display("FAIL wrap8_addr[%0d] got %h/%b want %h/%b", i, addrQ[i], transQ[i], expAddr[i], expTrans[i]); end
    end
    cmpCount++; if (rdAddrQ.size() !== 8) begin failCount++; $display("FAIL wrap8_nrd got %0d want 8", rdAddrQ.size()); end
  endtask

  task automatic test_stall();
    bit to;
    clearLogs();
    stallBeat = 2; stallLeft = 2;
    buildExpected(32'h100, 3'd3, 3'd2, 8'd0);
    startBurst(32'h100, 1'b0, 3'd3, 3'd2, 8'd0);
    waitDone(100, to);
    cmpCount++; if (to || addrQ.size() !== 4) begin failCount++; $display("FAIL stall_nbeats got %0d timeout %b want 4", addrQ.size(), to); end
    for (int i = 0; i < addrQ.size() && i < expAddr.size(); i++) begin
      cmpCount++; if (addrQ[i] !== expAddr[i] || transQ[i] !== expTrans[i]) begin failCount++;
        $display("FAIL stall_addr[%0d] got %h/%b want %h/%b", i, addrQ[i], transQ[i], expAddr[i], expTrans[i]); end
    end
    cmpCount++; if (stallCnt !== 2 || holdErr !== 0) begin failCount++; $display("FAIL stall_hold got stalls %0d changes %0d want 2 0", stallCnt, holdErr); end
    cmpCount++; if (rdAddrQ.size() !== 4) begin failCount++; $display("FAIL stall_nrd got %0d want 4", rdAddrQ.size()); end
    for (int i = 0; i < rdAddrQ.size() && i < expAddr.size(); i++) begin
      cmpCount++; if (rdAddrQ[i] !== expAddr[i] || rdDataQ[i] !== memf(expAddr[i])) begin failCount++;
        $display("FAIL stall_rd[%0d] got %h:%h want %h:%h", i, rdAddrQ[i], rdDataQ[i], expAddr[i], memf(expAddr[i])); end
    end
  endtask

  task automatic test_incr_boundary();
    bit to;
    clearLogs();
    buildExpected(32'h3FC, 3'd1, 3'd2, 8'd2);
    startBurst(32'h3FC, 1'b0, 3'd1, 3'd2, 8'd2);
    waitDone(100, to);
    cmpCount++; if (to || addrQ.size() !== 3) begin failCount++; $display("FAIL incr1k_nbeats got %0d timeout %b want 3", addrQ.size(), to); end
    for (int i = 0; i < addrQ.size() && i < expAddr.size(); i++) begin
      cmpCount++; if (addrQ[i] !== expAddr[i] || transQ[i] !== expTrans[i]) begin failCount++;
        $display("FAIL incr1k_addr[%0d] got %h/%b want %h/%b", i, addrQ[i], transQ[i], expAddr[i], expTrans[i]); end
    end
  endtask

  task automatic test_error();
    bit to;
    clearLogs();
    errBeat = 3;
    buildExpected(32'h200, 3'd5, 3'd2, 8'd0);
    startBurst(32'h200, 1'b0, 3'd5, 3'd2, 8'd0);
    waitDone(100, to);
    cmpCount++; if (to || doneErr !== 1'b1) begin failCount++; $display("FAIL error_flag got err %b timeout %b want err 1", doneErr, to); end
    cmpCount++; if (doneCycle !== hrespCycle + 1 || doneTrans !== 2'b00) begin failCount++;
      $display("FAIL error_timing got done cycle %0d htrans %b want cycle %0d htrans 00", doneCycle, doneTrans, hrespCycle + 1); end
    tick(); tick(); tick();
    cmpCount++; if (addrQ.size() !== 4) begin failCount++; $display("FAIL error_addr_count got %0d want 4", addrQ.size()); end
    cmpCount++; if (rdAddrQ.size() !== 2 || doneCnt !== 1) begin failCount++;
      $display("FAIL error_beats got rd %0d done %0d want 2 1", rdAddrQ.size(), doneCnt); end
    for (int i = 0; i < rdAddrQ.size() && i < 2; i++) begin
      cmpCount++; if (rdAddrQ[i] !== expAddr[i] || rdDataQ[i] !== memf(expAddr[i])) begin failCount++;
        $display("FAIL error_rd[%0d] got %h:%h want %h:%h", i, rdAddrQ[i], rdDataQ[i], expAddr[i], memf(expAddr[i])); end
    end
  endtask

  task automatic test_reset_midburst();
    bit to;
    clearLogs();
    startBurst(32'h0000_1240, 1'b0, 3'd6, 3'd2, 8'd0);
    tick(); tick(); tick();
    rstn = 1'b0;
    #1;
    cmpCount++; if ({htrans, haddr, hwrite, hburst, hsize} !== 41'd0 || req_ready !== 1'b1) begin failCount++;
      $display("FAIL midrst_bus got htrans=%b haddr=%h burst=%0d ready=%b want reset values", htrans, haddr, hburst, req_ready); end
    cmpCount++; if ({rd_valid, done, err} !== 3'b000 || {rd_data, rd_addr} !== 64'd0) begin failCount++;
      $display("FAIL midrst_rd got pulses %b data %h addr %h want 0", {rd_valid, done, err}, rd_data, rd_addr); end
    tick(); tick();
    rstn = 1'b1;
    tick();
    cmpCount++; if (doneCnt !== 0) begin failCount++; $display("FAIL midrst_no_done got %0d want 0", doneCnt); end
    clearLogs();
    buildExpected(32'h34, 3'd2, 3'd2, 8'd0);
    startBurst(32'h34, 1'b0, 3'd2, 3'd2, 8'd0);
    cmpCount++; if (htrans !== NSEQ || haddr !== 32'h34) begin failCount++; $display("FAIL midrst_restart got %b/%h want 10/00000034", htrans, haddr); end
    waitDone(100, to);
    cmpCount++; if (to || addrQ.size() !== 4 || rdAddrQ.size() !== 4 || doneCnt !== 1) begin failCount++;
      $display("FAIL midrst_rerun got addr %0d rd %0d done %0d want 4 4 1", addrQ.size(), rdAddrQ.size(), doneCnt); end
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [31:0] a;
    logic [2:0] b, s;
    logic [7:0] len;
    logic w;
    randReady = 1'b1;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      if (n % 2 == 1) a = (a & 32'hFFFF_FC00) | 32'h3C0 | 32'($urandom_range(0, 63));
      b = 3'($urandom_range(0, 7));
      s = 3'($urandom_range(0, 3));
      len = 8'($urandom_range(0, 15));
      w = ($urandom_range(0, 3) == 0);
      clearLogs();
      buildExpected(a, b, s, len);
      startBurst(a, w, b, s, len);
      cmpCount++; if (htrans !== NSEQ || haddr !== expAddr[0]) begin failCount++;
        $display("FAIL b2b_first[%0d] got %b/%h want 10/%h", n, htrans, haddr, expAddr[0]); end
      waitDone(400, to);
      cmpCount++; if (to || doneErr !== 1'b0 || req_ready !== 1'b1) begin failCount++;
        $display("FAIL b2b_done[%0d] got timeout %b err %b ready %b want 0 0 1", n, to, doneErr, req_ready); end
      cmpCount++; if (addrQ.size() !== expAddr.size()) begin failCount++;
        $display("FAIL b2b_nbeats[%0d] got %0d want %0d", n, addrQ.size(), expAddr.size()); end
      for (int i = 0; i < addrQ.size() && i < expAddr.size(); i++) begin
        cmpCount++; if (addrQ[i] !== expAddr[i] || transQ[i] !== expTrans[i]) begin failCount++;
          $display("FAIL b2b_addr[%0d.%0d] got %h/%b want %h/%b", n, i, addrQ[i], transQ[i], expAddr[i], expTrans[i]); end
      end
      cmpCount++; if (rdAddrQ.size() !== (w ? 0 : expAddr.size())) begin failCount++;
        $display("FAIL b2b_nrd[%0d] got %0d want %0d", n, rdAddrQ.size(), w ? 0 : expAddr.size()); end
      for (int i = 0; i < rdAddrQ.size() && i < expAddr.size(); i++) begin
        cmpCount++; if (rdAddrQ[i] !== expAddr[i] || rdDataQ[i] !== memf(expAddr[i])) begin failCount++;
          $display("FAIL b2b_rd[%0d.%0d] got %h:%h want %h:%h", n, i, rdAddrQ[i], rdDataQ[i], expAddr[i], memf(expAddr[i])); end
      end
    end
    randReady = 1'b0;
    cmpCount++; if (busyCnt !== 0) begin failCount++; $display("FAIL no_busy got %0d BUSY cycles want 0", busyCnt); end
  endtask

  initial begin
    test_reset();
    test_wrap4();
    test_wrap8();
    test_stall();
    test_incr_boundary();
    test_error();
    test_reset_midburst();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
